edge_stamper: RTL and testbench
===============================

// Module: edge_stamper
// PURPOSE
//  Front end of the delay line. Synchronises the async input sig_in and detects the selected edge(s).
//  For each accepted edge, computes a release timestamp = count + delay (mod 2^WIDTH).
//  Pushes the timestamp into the timestamp FIFO that feeds the downstream comparator.
//  Drops and flags events when the FIFO is full or during the holdoff window.
// PARAMETERS
//  WIDTH        8  timestamp / free-running counter width
//  SYNC_STAGES  2  synchroniser flops on sig_in (>=2)
//  EDGE         0  0 = rising, 1 = falling, 2 = both edges
//  HOLDOFF      0  min idle cycles after a push before the next edge is accepted
// PORTS
//  clk          in   1      clock
//  n_reset      in   1      reset, synchronous, active-low
//  sig_in       in   1      asynchronous input pulse train
//  count        in   WIDTH  free-running timebase, shared with the comparator
//  delay        in   WIDTH  delay in clk cycles; quasi-static
//  full         in   1      FIFO full
//  wr_en        out  1      FIFO write strobe, one cycle per push
//  wr_data      out  WIDTH  timestamp; valid while wr_en=1
//  overflow     out  1      sticky: an edge was lost because the FIFO was full
//  clr_overflow in   1      clears overflow (sync)
//  drop_count   out  16     only with EDGE_STAMPER_DROPCNT_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (n_reset=0 at a clk edge):
//   - sync chain and previous-sample reg <= 0; state <= IDLE.
//   - wr_en=0, wr_data=0, overflow=0, drop_count=0, holdoff counter=0.
//   - Edge detection is disarmed for SYNC_STAGES+1 cycles after reset release.
//     A level already present on sig_in at release is not an edge.
//   - Reset asserted mid-WRITE aborts the push: wr_en=0 on the next cycle.
//  Detect: edge = sync_out vs previous sample, per EDGE.
//   - Latency sig_in edge -> detect: SYNC_STAGES cycles (+1 for metastability).
//  Stamp: wr_data <= count + delay, computed in the detect cycle, truncated to WIDTH.
//   - The wrap is intended; the comparator matches on equality.
//   - Usable delay is >= 4. Smaller values produce a stamp already passed; that
//     event releases one full wrap (2^WIDTH cycles) late. Not checked in RTL.
//  FSM (wr_en = state==WRITE, registered):
//   IDLE : edge & armed & !full  -> WRITE (load wr_data)
//          edge & armed & full   -> IDLE, overflow<=1, drop++
//   WRITE: one push cycle.
//          If HOLDOFF=0 and the same-cycle rule accepts an edge (!full): WRITE again,
//            i.e. a back-to-back push.
//          Else if HOLDOFF>0: HOLD with cnt<=HOLDOFF-1.
//          Else: IDLE.
//   HOLD : edges ignored, drop++ (overflow unchanged); cnt==0 -> IDLE, else cnt--.
//  Full is sampled in the detect cycle. This block is the sole FIFO writer, so the
//   FIFO cannot fill between check and push.
//  The FIFO must never see wr_en while full.
//  Simultaneous overflow set and clr_overflow: set wins.
//  Edges during the disarmed window are ignored and not counted.
// CONFIGURATION
//  EDGE_STAMPER_DROPCNT_EN defined:
//   - drop_count is a 16-bit saturating (0xFFFF) count of every dropped edge
//     (full or HOLD).
//   - clr_overflow also clears drop_count.
//  Not defined:
//   - port drop_count absent, no counter logic.
//   - overflow behaviour is unchanged.
// TESTING
//  1. WIDTH=8, delay=20, rising pulse at count=0x10.
//     -> one wr_en after 3 cycles, wr_data=0x24+3 (stamp uses count at detect).
//  2. delay=0x30, edge detected at count=0xE0 -> wr_data=0x10 (wrap).
//  3. full=1, edge -> no wr_en, overflow=1, drop_count=1.
//     clr_overflow -> overflow=0, drop_count=0.
//  4. HOLDOFF=5, edges 2 cycles apart -> first pushed, second dropped
//     (drop_count=1, overflow=0); edge 7 cycles later is pushed.
//  5. EDGE=2, HOLDOFF=0, sig_in toggling every cycle -> wr_en high continuously,
//     one stamp per edge, consecutive stamps +1.
//  6. sig_in held high through reset release -> no push.
//     Reset asserted during WRITE -> wr_en=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/edge_stamper.sv
`timescale 1ns/1ps
// Synchronises sig_in, stamps selected edges with count+delay and pushes them to the timestamp FIFO.
// wr_en appears SYNC_STAGES+1 cycles after sig_in settles. Edges are dropped when full is high or during holdoff. EDGE_STAMPER_DROPCNT_EN adds drop_count.
module edge_stamper #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE        = 0,
  parameter int HOLDOFF     = 0
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             sig_in,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] delay,
  input  logic             full,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             overflow,
  input  logic             clr_overflow
`ifdef EDGE_STAMPER_DROPCNT_EN
  ,
  output logic [15:0]      drop_count
`endif
);
  localparam int HC_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  localparam logic [HC_W-1:0]  HC_LOAD  = HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [ARM_W-1:0]       arm_q, arm_d;
  logic [HC_W-1:0]        hcnt_q, hcnt_d;
  logic [WIDTH-1:0]       wr_data_q, wr_data_d;
  logic                   overflow_q, overflow_d;

  logic sync_out, armed, rise, fall, edge_det, drop_full;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // The chain clears in reset, so a level held through release looks like an edge until it has propagated.
  assign armed    = (arm_q == ARM_DONE);
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;
  assign edge_det = armed & ((EDGE == 0) ? rise : (EDGE == 1) ? fall : (rise | fall));

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d    = sync_out;
    arm_d     = armed ? arm_q : arm_q + ARM_W'(1);
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    wr_data_d = wr_data_q;
    drop_full = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_det) begin
          if (full) begin
            drop_full = 1'b1;
          end else begin
            state_d   = WRITE;
            wr_data_d = count + delay;
          end
        end
      end
      WRITE: begin
        if (HOLDOFF == 0) begin
          if (edge_det && !full) begin
            state_d   = WRITE;
            wr_data_d = count + delay;
          end else begin
            state_d   = IDLE;
            drop_full = edge_det;
          end
        end else begin
          state_d = HOLD;
          hcnt_d  = HC_LOAD;
        end
      end
      HOLD: begin
        if (hcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q - HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    overflow_d = (overflow_q & ~clr_overflow) | drop_full;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      arm_q      <= '0;
      state_q    <= IDLE;
      hcnt_q     <= '0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      arm_q      <= arm_d;
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      wr_data_q  <= wr_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en    = (state_q == WRITE);
  assign wr_data  = wr_data_q;
  assign overflow = overflow_q;

`ifdef EDGE_STAMPER_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        dropped;

  // An edge during the holdoff push cycle is lost as well, so it counts like one seen in HOLD.
  assign dropped = drop_full |
                   (edge_det & ((state_q == HOLD) || ((state_q == WRITE) && (HOLDOFF != 0))));

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow) begin
      drop_cnt_d = '0;
    end
    if (dropped && (drop_cnt_d != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_edge_stamper.sv
`timescale 1ns/1ps
// Three edge_stamper instances (rising / both edges / falling with holdoff) share one bench-driven timebase.
// Stamps are predicted when sig_* is driven and matched in order whenever wr_en is seen.
module tb_edge_stamper;
  localparam int W   = 8;
  localparam int LAT = 2;  // count advance between driving sig_in and the detect cycle

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_reset, clr_overflow;
  logic [W-1:0] count, delay;
  logic         sig_a, sig_b, sig_c, full_a, full_b, full_c;
  logic         wr_en_a, wr_en_b, wr_en_c, ovf_a, ovf_b, ovf_c;
  logic [W-1:0] wd_a, wd_b, wd_c;
`ifdef EDGE_STAMPER_DROPCNT_EN
  logic [15:0]  drop_a, drop_b, drop_c;
`endif

  int errors = 0;
  int checks = 0;
  int n_a = 0, n_b = 0, n_c = 0;
  int base;
  logic [W-1:0] q_a[$], q_b[$], q_c[$];
  logic [7:0]   pat_c;

  edge_stamper #(.WIDTH(W), .SYNC_STAGES(2), .EDGE(0), .HOLDOFF(0)) dut_a (
    .clk(clk), .n_reset(n_reset), .sig_in(sig_a), .count(count), .delay(delay),
    .full(full_a), .wr_en(wr_en_a), .wr_data(wd_a), .overflow(ovf_a),
    .clr_overflow(clr_overflow)
`ifdef EDGE_STAMPER_DROPCNT_EN
    , .drop_count(drop_a)
`endif
  );

  edge_stamper #(.WIDTH(W), .SYNC_STAGES(2), .EDGE(2), .HOLDOFF(0)) dut_b (
    .clk(clk), .n_reset(n_reset), .sig_in(sig_b), .count(count), .delay(delay),
    .full(full_b), .wr_en(wr_en_b), .wr_data(wd_b), .overflow(ovf_b),
    .clr_overflow(clr_overflow)
`ifdef EDGE_STAMPER_DROPCNT_EN
    , .drop_count(drop_b)
`endif
  );

  edge_stamper #(.WIDTH(W), .SYNC_STAGES(2), .EDGE(1), .HOLDOFF(5)) dut_c (
    .clk(clk), .n_reset(n_reset), .sig_in(sig_c), .count(count), .delay(delay),
    .full(full_c), .wr_en(wr_en_c), .wr_data(wd_c), .overflow(ovf_c),
    .clr_overflow(clr_overflow)
`ifdef EDGE_STAMPER_DROPCNT_EN
    , .drop_count(drop_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Stamp the DUT should produce for an edge driven now.
  function automatic logic [W-1:0] stamp();
    return count + delay + W'(LAT);
  endfunction

  // One clock: sample outputs at the falling edge, match pushes, then advance the timebase.
  task automatic tick();
    @(negedge clk);
    if (wr_en_a) begin
      n_a++;
      chk("a_push_expected", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) chk("a_stamp", 32'(wd_a), 32'(q_a.pop_front()));
      chk("a_wr_while_full", 32'(full_a), 0);
    end
    if (wr_en_b) begin
      n_b++;
      chk("b_push_expected", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) chk("b_stamp", 32'(wd_b), 32'(q_b.pop_front()));
    end
    if (wr_en_c) begin
      n_c++;
      chk("c_push_expected", 32'(q_c.size() != 0), 1);
      if (q_c.size() != 0) chk("c_stamp", 32'(wd_c), 32'(q_c.pop_front()));
    end
    count = count + W'(1);
  endtask

  initial begin
    n_reset = 1'b0; clr_overflow = 1'b0; count = '0; delay = 8'd20;
    sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b1;
    full_a = 1'b0; full_b = 1'b0; full_c = 1'b0;
    pat_c = 8'b0111_1010;
    repeat (3) tick();
    chk("rst_wr_en_a", wr_en_a, 0);
    chk("rst_wr_data_a", wd_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_wr_en_b", wr_en_b, 0);
    chk("rst_wr_en_c", wr_en_c, 0);
`ifdef EDGE_STAMPER_DROPCNT_EN
    chk("rst_drop_a", drop_a, 0);
`endif
    n_reset = 1'b1;
    repeat (6) tick();

    // Pulse lands while count=0x10 and is captured one clock late: detect cycle sees 0x13 -> 0x13+0x14.
    count = 8'h10;
    tick();
    sig_a = 1'b1;
    q_a.push_back(8'h27);
    tick(); chk("a_lat_cycle1", wr_en_a, 0);
    tick(); chk("a_lat_cycle2", wr_en_a, 0);
    tick(); chk("a_lat_cycle3", wr_en_a, 1);
    tick(); chk("a_single_push", wr_en_a, 0);
    sig_a = 1'b0;
    repeat (3) tick();
    chk("a_first_drain", q_a.size(), 0);

    // Wrap: detect at count 0xE0 with delay 0x30 -> 0x10.
    delay = 8'h30;
    count = 8'hDE;
    sig_a = 1'b1;
    q_a.push_back(8'h10);
    repeat (4) tick();
    chk("a_wrap_pushes", n_a, 2);
    sig_a = 1'b0;
    delay = 8'd20;
    repeat (3) tick();

    // Full: edge dropped, overflow set, then cleared.
    full_a = 1'b1;
    sig_a  = 1'b1;
    repeat (5) tick();
    chk("a_full_no_push", n_a, 2);
    chk("a_full_overflow", ovf_a, 1);
`ifdef EDGE_STAMPER_DROPCNT_EN
    chk("a_full_drop", drop_a, 1);
`endif
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("a_clr_overflow", ovf_a, 0);
`ifdef EDGE_STAMPER_DROPCNT_EN
    chk("a_clr_drop", drop_a, 0);
`endif
    // A clear landing in the same cycle as a full drop loses to the set.
    sig_a = 1'b0;
    repeat (2) tick();
    sig_a = 1'b1;
    repeat (2) tick();
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("a_set_wins", ovf_a, 1);
    sig_a = 1'b0;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    full_a = 1'b0;
    chk("a_overflow_cleared", ovf_a, 0);
    repeat (3) tick();

    // Holdoff=5 on falling edges: fall at 0 pushed, fall at +2 dropped, fall at +7 pushed.
    for (int i = 0; i < 8; i++) begin
      sig_c = pat_c[i];
      if (i == 0 || i == 7) q_c.push_back(stamp());
      tick();
    end
    sig_c = 1'b1;
    repeat (6) tick();
    chk("c_holdoff_pushes", n_c, 2);
    chk("c_holdoff_drain", q_c.size(), 0);
    chk("c_holdoff_no_overflow", ovf_c, 0);
`ifdef EDGE_STAMPER_DROPCNT_EN
    chk("c_holdoff_drop", drop_c, 1);
`endif

    // Both edges, toggling every cycle: continuous wr_en, stamps stepping by one.
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        sig_b = ~sig_b;
        q_b.push_back(stamp());
      end
      tick();
      if (i >= 2 && i <= 9) chk("b_stream_wr_en", wr_en_b, 1);
      if (i == 10) chk("b_stream_end", wr_en_b, 0);
    end
    chk("b_stream_pushes", n_b, 8);
    chk("b_stream_drain", q_b.size(), 0);

    // Level held high through reset release is not an edge.
    n_reset = 1'b0;
    sig_a   = 1'b1;
    repeat (3) tick();
    n_reset = 1'b1;
    base = n_a;
    repeat (12) tick();
    chk("a_level_at_release", n_a - base, 0);

    // Reset mid-stream: wr_en drops the next cycle and every output returns to its reset value.
    for (int i = 0; i < 5; i++) begin
      sig_b = ~sig_b;
      q_b.push_back(stamp());
      tick();
    end
    chk("b_before_abort", wr_en_b, 1);
    base = n_b;
    n_reset = 1'b0;
    q_b.delete();
    tick();
    chk("b_abort_wr_en", wr_en_b, 0);
    chk("b_abort_wr_data", wd_b, 0);
    chk("b_abort_ovf", ovf_b, 0);
`ifdef EDGE_STAMPER_DROPCNT_EN
    chk("c_abort_drop", drop_c, 0);
`endif
    n_reset = 1'b1;
    repeat (8) tick();
    chk("b_abort_no_push", n_b - base, 0);
    chk("a_final_drain", q_a.size(), 0);
    chk("c_final_drain", q_c.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
